// File: rtl/jtag_tap_ctrl.sv
// IEEE 1149.1 TAP controller: 16-state FSM, IR path, BYPASS and tdo mux.
// Define JTAG_TAP_IDCODE_EN to add the built-in 32-bit IDCODE register.
module jtag_tap_ctrl #(
  parameter int unsigned       IR_LEN        = 4,
  parameter logic [IR_LEN-1:0] IDCODE_OPCODE = IR_LEN'(1),
  parameter logic [31:0]       IDCODE_VALUE  = 32'h1000_0001
) (
  input  logic              tck,
  input  logic              trst,
  input  logic              tms,
  input  logic              tdi,
  output logic              tdo,
  output logic              tdo_en,
  input  logic              dr_tdo,
  output logic              state_tlr,
  output logic              state_capturedr,
  output logic              state_shiftdr,
  output logic              state_updatedr,
  output logic              state_runidle,
  output logic [IR_LEN-1:0] ir_reg
);

  typedef enum logic [3:0] {
    TLR, RTI,
    SEL_DR, CAP_DR, SH_DR, EX1_DR,
    PAU_DR, EX2_DR, UPD_DR,
    SEL_IR, CAP_IR, SH_IR, EX1_IR,
    PAU_IR, EX2_IR, UPD_IR
  } tap_state_e;

`ifdef JTAG_TAP_IDCODE_EN
  localparam logic [IR_LEN-1:0] IR_RESET = IDCODE_OPCODE;
`else
  localparam logic [IR_LEN-1:0] IR_RESET = '1;
`endif

  localparam logic [IR_LEN-1:0] IR_CAPTURE =
    {{(IR_LEN-2){1'b0}}, 2'b01};

  tap_state_e state_q;
  tap_state_e state_d;

  logic [IR_LEN-1:0] ir_shift;
  logic              bypass_reg;
  logic              bypass_sel;

  logic st_cap_ir;
  logic st_sh_ir;
  logic st_upd_ir;

  always_ff @(posedge tck or negedge trst) begin
    if (!trst) state_q <= TLR;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      TLR:    state_d = tms ? TLR    : RTI;
      RTI:    state_d = tms ? SEL_DR : RTI;
      SEL_DR: state_d = tms ? SEL_IR : CAP_DR;
      CAP_DR: state_d = tms ? EX1_DR : SH_DR;
      SH_DR:  state_d = tms ? EX1_DR : SH_DR;
      EX1_DR: state_d = tms ? UPD_DR : PAU_DR;
      PAU_DR: state_d = tms ? EX2_DR : PAU_DR;
      EX2_DR: state_d = tms ? UPD_DR : SH_DR;
      UPD_DR: state_d = tms ? SEL_DR : RTI;
      SEL_IR: state_d = tms ? TLR    : CAP_IR;
      CAP_IR: state_d = tms ? EX1_IR : SH_IR;
      SH_IR:  state_d = tms ? EX1_IR : SH_IR;
      EX1_IR: state_d = tms ? UPD_IR : PAU_IR;
      PAU_IR: state_d = tms ? EX2_IR : PAU_IR;
      EX2_IR: state_d = tms ? UPD_IR : SH_IR;
      UPD_IR: state_d = tms ? SEL_DR : RTI;
      default: state_d = TLR;
    endcase
  end

  assign state_tlr       = (state_q == TLR);
  assign state_runidle   = (state_q == RTI);
  assign state_capturedr = (state_q == CAP_DR);
  assign state_shiftdr   = (state_q == SH_DR);
  assign state_updatedr  = (state_q == UPD_DR);

  assign st_cap_ir = (state_q == CAP_IR);
  assign st_sh_ir  = (state_q == SH_IR);
  assign st_upd_ir = (state_q == UPD_IR);

  assign tdo_en = st_sh_ir | state_shiftdr;

  always_ff @(posedge tck or negedge trst) begin
    if (!trst) begin
      ir_shift <= '0;
    end else if (st_cap_ir) begin
      ir_shift <= IR_CAPTURE;
    end else if (st_sh_ir) begin
      ir_shift <= {tdi, ir_shift[IR_LEN-1:1]};
    end
  end

  always_ff @(posedge tck or negedge trst) begin
    if (!trst) begin
      ir_reg <= IR_RESET;
    end else if (state_tlr) begin
      ir_reg <= IR_RESET;
    end else if (st_upd_ir) begin
      ir_reg <= ir_shift;
    end
  end

  assign bypass_sel = &ir_reg;

  always_ff @(posedge tck or negedge trst) begin
    if (!trst) begin
      bypass_reg <= 1'b0;
    end else if (bypass_sel) begin
      if (state_capturedr)    bypass_reg <= 1'b0;
      else if (state_shiftdr) bypass_reg <= tdi;
    end
  end

`ifdef JTAG_TAP_IDCODE_EN
  logic [31:0] id_shift;
  logic        idcode_sel;

  assign idcode_sel = (ir_reg == IDCODE_OPCODE);

  always_ff @(posedge tck or negedge trst) begin
    if (!trst) begin
      id_shift <= '0;
    end else if (idcode_sel && !bypass_sel) begin
      if (state_capturedr)    id_shift <= IDCODE_VALUE;
      else if (state_shiftdr) id_shift <= {tdi, id_shift[31:1]};
    end
  end

  always_comb begin
    tdo = 1'b0;
    if (st_sh_ir)                    tdo = ir_shift[0];
    else if (state_shiftdr) begin
      if (bypass_sel)                tdo = bypass_reg;
      else if (idcode_sel)           tdo = id_shift[0];
      else                           tdo = dr_tdo;
    end
  end
`else
  // IDCODE parameters have no internal meaning in this build
  logic cfg_unused;
  assign cfg_unused = ^{IDCODE_OPCODE, IDCODE_VALUE};

  always_comb begin
    tdo = 1'b0;
    if (st_sh_ir)           tdo = ir_shift[0];
    else if (state_shiftdr) tdo = bypass_sel ? bypass_reg : dr_tdo;
  end
`endif

endmodule
